// File: rtl/multi_intersection_ctrl_pkg.sv
// Shared definitions for the multi-intersection traffic controller:
// phase encodings, lamp bit positions and phase sequencing helpers.
package multi_intersection_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_NRTH_GRN = 3'd1,
    S_NRTH_YLW = 3'd2,
    S_ALLRED_N = 3'd3,
    S_WEST_GRN = 3'd4,
    S_WEST_YLW = 3'd5,
    S_ALLRED_W = 3'd6
  } state_e;

  localparam int unsigned LAMP_RED = 0;
  localparam int unsigned LAMP_YLW = 1;
  localparam int unsigned LAMP_GRN = 2;

  typedef struct packed {
    logic [2:0] nrth;
    logic [2:0] west;
  } lamps_t;

  function automatic state_e next_state(input state_e s);
    case (s)
      S_INIT:     next_state = S_NRTH_GRN;
      S_NRTH_GRN: next_state = S_NRTH_YLW;
      S_NRTH_YLW: next_state = S_ALLRED_N;
      S_ALLRED_N: next_state = S_WEST_GRN;
      S_WEST_GRN: next_state = S_WEST_YLW;
      S_WEST_YLW: next_state = S_ALLRED_W;
      S_ALLRED_W: next_state = S_NRTH_GRN;
      default:    next_state = S_INIT;
    endcase
  endfunction

  // Both directions default to red; only the green/yellow phases light one side.
  function automatic lamps_t lamps_of(input state_e s);
    lamps_t l;
    l = '0;
    l.nrth[LAMP_RED] = 1'b1;
    l.west[LAMP_RED] = 1'b1;
    case (s)
      S_NRTH_GRN: begin l.nrth[LAMP_RED] = 1'b0; l.nrth[LAMP_GRN] = 1'b1; end
      S_NRTH_YLW: begin l.nrth[LAMP_RED] = 1'b0; l.nrth[LAMP_YLW] = 1'b1; end
      S_WEST_GRN: begin l.west[LAMP_RED] = 1'b0; l.west[LAMP_GRN] = 1'b1; end
      S_WEST_YLW: begin l.west[LAMP_RED] = 1'b0; l.west[LAMP_YLW] = 1'b1; end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/multi_intersection_ctrl_fsm.sv
// One intersection: phase FSM with registered lamps, pedestrian request
// synchronisers/latches and per-direction walk timers.
module multi_intersection_ctrl_fsm
  import multi_intersection_ctrl_pkg::*;
#(
  parameter int unsigned GRN_T    = 20,
  parameter int unsigned YLW_T    = 3,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned WALK_T   = 7,
  parameter int unsigned INIT_T   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_pedo_nrth,
  input  logic       i_pedo_west,
  output logic [2:0] o_lamp_nrth,
  output logic [2:0] o_lamp_west,
  output logic       o_walk_nrth,
  output logic       o_stop_nrth,
  output logic       o_walk_west,
  output logic       o_stop_west
);

  localparam int unsigned MAX_GY = (GRN_T > YLW_T) ? GRN_T : YLW_T;
  localparam int unsigned MAX_PH = (MAX_GY > ALLRED_T) ? MAX_GY : ALLRED_T;
  localparam int unsigned MAX_T  = (MAX_PH > INIT_T) ? MAX_PH : INIT_T;
  localparam int unsigned TW     = $clog2(MAX_T) + 1;
  localparam int unsigned WW     = $clog2(WALK_T) + 1;

  state_e          r_state;
  logic [TW-1:0]   r_timer;
  lamps_t          r_lamps;
  logic [1:0]      r_sync_n, r_sync_w;
  logic            r_prev_n, r_prev_w;
  logic            r_req_n, r_req_w;
  logic            r_walk_n, r_walk_w;
  logic [WW-1:0]   r_wt_n, r_wt_w;

  state_e w_next;
  logic   w_leave, w_edge_n, w_edge_w, w_grant_n, w_grant_w;

  function automatic logic [TW-1:0] dur(input state_e s);
    case (s)
      S_NRTH_GRN, S_WEST_GRN: dur = TW'(GRN_T);
      S_NRTH_YLW, S_WEST_YLW: dur = TW'(YLW_T);
      default:                dur = TW'(ALLRED_T);
    endcase
  endfunction

  assign w_next    = next_state(r_state);
  assign w_leave   = i_tick && (r_timer == TW'(1));
  assign w_edge_n  = r_sync_n[1] & ~r_prev_n;
  assign w_edge_w  = r_sync_w[1] & ~r_prev_w;
  assign w_grant_n = w_leave && (w_next == S_NRTH_GRN) && r_req_n;
  assign w_grant_w = w_leave && (w_next == S_WEST_GRN) && r_req_w;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_n <= '0;
      r_sync_w <= '0;
      r_prev_n <= 1'b0;
      r_prev_w <= 1'b0;
    end else begin
      r_sync_n <= {r_sync_n[0], i_pedo_nrth};
      r_sync_w <= {r_sync_w[0], i_pedo_west};
      r_prev_n <= r_sync_n[1];
      r_prev_w <= r_sync_w[1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_INIT;
      r_timer  <= TW'(INIT_T);
      r_lamps  <= lamps_of(S_INIT);
      r_req_n  <= 1'b0;
      r_req_w  <= 1'b0;
      r_walk_n <= 1'b0;
      r_walk_w <= 1'b0;
      r_wt_n   <= '0;
      r_wt_w   <= '0;
    end else begin
      // A new edge arriving on the grant cycle survives the clear.
      r_req_n <= (r_req_n & ~w_grant_n) | w_edge_n;
      r_req_w <= (r_req_w & ~w_grant_w) | w_edge_w;
      if (i_tick) begin
        if (w_leave) begin
          r_state <= w_next;
          r_timer <= dur(w_next);
          r_lamps <= lamps_of(w_next);
        end else begin
          r_timer <= r_timer - TW'(1);
        end
      end
      if (w_grant_n) begin
        r_walk_n <= 1'b1;
        r_wt_n   <= WW'(WALK_T);
      end else if (r_walk_n && i_tick) begin
        if (r_wt_n == WW'(1) || w_leave) r_walk_n <= 1'b0;
        r_wt_n <= r_wt_n - WW'(1);
      end
      if (w_grant_w) begin
        r_walk_w <= 1'b1;
        r_wt_w   <= WW'(WALK_T);
      end else if (r_walk_w && i_tick) begin
        if (r_wt_w == WW'(1) || w_leave) r_walk_w <= 1'b0;
        r_wt_w <= r_wt_w - WW'(1);
      end
    end
  end

  assign o_lamp_nrth = r_lamps.nrth;
  assign o_lamp_west = r_lamps.west;
  assign o_walk_nrth = r_walk_n;
  assign o_stop_nrth = ~r_walk_n;
  assign o_walk_west = r_walk_w;
  assign o_stop_west = ~r_walk_w;

endmodule

// File: rtl/multi_intersection_ctrl.sv
// N-intersection traffic controller: shared tick prescaler feeding one
// phase FSM per intersection, each started with its own green-wave offset.
module multi_intersection_ctrl
  import multi_intersection_ctrl_pkg::*;
#(
  parameter int unsigned N_INT    = 2,
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned TICK_HZ  = 1,
  parameter int unsigned GRN_T    = 20,
  parameter int unsigned YLW_T    = 3,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned WALK_T   = 7,
  parameter int unsigned OFFSET_T = 4
) (
  input  logic             clk_50_mhz,
  input  logic             reset_n,
  input  logic [N_INT-1:0] nrth_pedo_req,
  input  logic [N_INT-1:0] west_pedo_req,
  output logic [N_INT-1:0] red_nrth,
  output logic [N_INT-1:0] ylw_nrth,
  output logic [N_INT-1:0] grn_nrth,
  output logic [N_INT-1:0] red_west,
  output logic [N_INT-1:0] ylw_west,
  output logic [N_INT-1:0] grn_west,
  output logic [N_INT-1:0] walk_nrth,
  output logic [N_INT-1:0] stop_nrth,
  output logic [N_INT-1:0] walk_west,
  output logic [N_INT-1:0] stop_west,
  output logic             tick_out
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);

  logic [PW-1:0] r_presc;
  logic          r_tick;

  always_ff @(posedge clk_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (r_presc == PW'(DIV - 1)) begin
      r_presc <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_presc <= r_presc + PW'(1);
      r_tick  <= 1'b0;
    end
  end

  assign tick_out = r_tick;

  for (genvar gi = 0; gi < N_INT; gi++) begin : g_int
    logic [2:0] w_lamp_n, w_lamp_w;

    multi_intersection_ctrl_fsm #(
      .GRN_T    (GRN_T),
      .YLW_T    (YLW_T),
      .ALLRED_T (ALLRED_T),
      .WALK_T   (WALK_T),
      .INIT_T   (ALLRED_T + gi * OFFSET_T)
    ) u_fsm (
      .i_clk       (clk_50_mhz),
      .i_rst_n     (reset_n),
      .i_tick      (r_tick),
      .i_pedo_nrth (nrth_pedo_req[gi]),
      .i_pedo_west (west_pedo_req[gi]),
      .o_lamp_nrth (w_lamp_n),
      .o_lamp_west (w_lamp_w),
      .o_walk_nrth (walk_nrth[gi]),
      .o_stop_nrth (stop_nrth[gi]),
      .o_walk_west (walk_west[gi]),
      .o_stop_west (stop_west[gi])
    );

    assign red_nrth[gi] = w_lamp_n[LAMP_RED];
    assign ylw_nrth[gi] = w_lamp_n[LAMP_YLW];
    assign grn_nrth[gi] = w_lamp_n[LAMP_GRN];
    assign red_west[gi] = w_lamp_w[LAMP_RED];
    assign ylw_west[gi] = w_lamp_w[LAMP_YLW];
    assign grn_west[gi] = w_lamp_w[LAMP_GRN];
  end

endmodule

// File: tb/tb_multi_intersection_ctrl.sv
// Directed bench for multi_intersection_ctrl with a 10-cycle tick, two
// intersections and an independent phase-timeline model checked every cycle.
module tb_multi_intersection_ctrl;

  localparam int N = 2;

  logic         clk, reset_n, tick;
  logic [N-1:0] nrth_req, west_req;
  logic [N-1:0] red_n, ylw_n, grn_n, red_w, ylw_w, grn_w;
  logic [N-1:0] walk_n, stop_n, walk_w, stop_w;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rises    = 0;
  logic prev_ww1 = 1'b0;

  multi_intersection_ctrl #(
    .N_INT(2), .CLK_HZ(10), .TICK_HZ(1), .GRN_T(4), .YLW_T(2),
    .ALLRED_T(1), .WALK_T(2), .OFFSET_T(3)
  ) dut (
    .clk_50_mhz    (clk),
    .reset_n       (reset_n),
    .nrth_pedo_req (nrth_req),
    .west_pedo_req (west_req),
    .red_nrth      (red_n),
    .ylw_nrth      (ylw_n),
    .grn_nrth      (grn_n),
    .red_west      (red_w),
    .ylw_west      (ylw_w),
    .grn_west      (grn_w),
    .walk_nrth     (walk_n),
    .stop_nrth     (stop_n),
    .walk_west     (walk_w),
    .stop_west     (stop_w),
    .tick_out      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // {red,ylw,grn} north then west, after posedge k since reset release.
  function automatic logic [5:0] exp_lamps(input int i, input int k);
    int e0, t;
    e0 = 10 * (1 + 3 * i) + 1;
    if (k < e0) return 6'b100_100;
    t = ((k - e0) / 10) % 14;
    if (t < 4)       return 6'b001_100;
    else if (t < 6)  return 6'b010_100;
    else if (t == 6) return 6'b100_100;
    else if (t < 11) return 6'b100_001;
    else if (t < 13) return 6'b100_010;
    else             return 6'b100_100;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++)
      check($sformatf("lamps%0d", i),
            32'({red_n[i], ylw_n[i], grn_n[i], red_w[i], ylw_w[i], grn_w[i]}),
            32'(exp_lamps(i, cyc)));
    check("tick", 32'(tick), 32'((cyc % 10) == 0));
    if (walk_w[1] && !prev_ww1) rises++;
    prev_ww1 = walk_w[1];
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_red_stop"}, 32'({red_n, red_w, stop_n, stop_w}), 32'hFF);
    check({tag, "_lit"}, 32'({ylw_n, grn_n, ylw_w, grn_w, walk_n, walk_w}), 32'h0);
    check({tag, "_tick"}, 32'(tick), 32'h0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        check("excl", 32'((grn_n[i] | ylw_n[i]) & (grn_w[i] | ylw_w[i])), 32'h0);
        check("walkn_grn", 32'(walk_n[i] & ~grn_n[i]), 32'h0);
        check("walkw_grn", 32'(walk_w[i] & ~grn_w[i]), 32'h0);
        check("stop_inv", 32'({stop_n[i], stop_w[i]}), 32'({~walk_n[i], ~walk_w[i]}));
      end
    end
  end

  task automatic startup_checks();
    run_to(9);
    check("pre_tick_grn0", 32'(grn_n[0]), 32'h0);
    run_to(10);
    check("tick1_grn0", 32'(grn_n[0]), 32'h0);
    run_to(11);
    check("grn0_rise", 32'(grn_n[0]), 32'h1);
    run_to(40);
    check("grn1_pre", 32'(grn_n[1]), 32'h0);
    run_to(41);
    check("grn1_rise", 32'(grn_n[1]), 32'h1);
  endtask

  initial begin
    reset_n  = 1'b1;
    nrth_req = '0;
    west_req = '0;
    #1 reset_n = 1'b0;
    #1 check_reset("rst_async");
    repeat (3) @(posedge clk);
    #1 check_reset("rst_hold");
    @(negedge clk) reset_n = 1'b1;
    cyc = 0;

    // Free running, no requests.
    startup_checks();
    run_to(151);
    check("grn0_period", 32'(grn_n[0]), 32'h1);
    run_to(320);

    // North request on int 0 during its west green.
    run_to(370);
    nrth_req[0] = 1'b1;
    run_to(372);
    nrth_req[0] = 1'b0;
    run_to(430);
    check("walk0_before", 32'(walk_n[0]), 32'h0);
    run_to(431);
    check("walk0_grant", 32'({walk_n[0], stop_n[0]}), 32'h2);
    run_to(450);
    check("walk0_last", 32'(walk_n[0]), 32'h1);
    run_to(451);
    check("walk0_end", 32'({walk_n[0], stop_n[0]}), 32'h1);
    run_to(571);
    check("walk0_cleared", 32'(walk_n[0]), 32'h0);

    // West request on int 1 held high for 40 ticks.
    run_to(600);
    west_req[1] = 1'b1;
    run_to(670);
    check("walkw1_before", 32'(walk_w[1]), 32'h0);
    run_to(671);
    check("walkw1_grant", 32'(walk_w[1]), 32'h1);
    run_to(690);
    check("walkw1_last", 32'(walk_w[1]), 32'h1);
    run_to(691);
    check("walkw1_end", 32'(walk_w[1]), 32'h0);
    run_to(811);
    check("walkw1_held_a", 32'(walk_w[1]), 32'h0);
    run_to(951);
    check("walkw1_held_b", 32'(walk_w[1]), 32'h0);
    run_to(1000);
    west_req[1] = 1'b0;
    run_to(1020);
    west_req[1] = 1'b1;
    run_to(1040);
    west_req[1] = 1'b0;
    run_to(1090);
    check("walkw1_one_grant", 32'(rises), 32'd1);
    run_to(1091);
    check("walkw1_regrant", 32'(walk_w[1]), 32'h1);
    check("walkw1_two_grants", 32'(rises), 32'd2);

    // Request edge landing on the grant cycle of int 0.
    run_to(1150);
    nrth_req[0] = 1'b1;
    run_to(1152);
    nrth_req[0] = 1'b0;
    run_to(1268);
    nrth_req[0] = 1'b1;
    run_to(1270);
    check("coinc_before", 32'(walk_n[0]), 32'h0);
    run_to(1271);
    check("coinc_grant", 32'(walk_n[0]), 32'h1);
    run_to(1280);
    nrth_req[0] = 1'b0;
    run_to(1291);
    check("coinc_end", 32'(walk_n[0]), 32'h0);
    run_to(1410);
    check("coinc_next_pre", 32'(walk_n[0]), 32'h0);
    run_to(1411);
    check("coinc_next_grant", 32'(walk_n[0]), 32'h1);

    // Reset asserted while int 0 is yellow and int 1 is green.
    run_to(1460);
    check("mid_ylw0", 32'(ylw_n[0]), 32'h1);
    #1 reset_n = 1'b0;
    #1 check_reset("rst_mid");
    repeat (3) @(posedge clk);
    #1 check_reset("rst_mid_hold");
    @(negedge clk) reset_n = 1'b1;
    cyc = 0;
    startup_checks();
    run_to(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
